// File: rtl/apb_req_master.sv
// -----------------------------------------------------------------------------
// apb_req_master
//
// Converts a valid/ready request into a single APB3/APB4 transfer and returns
// the result on a valid/ready response channel. Only one transfer is in flight
// at a time. An optional ACCESS-phase watchdog aborts transfers to slaves that
// never assert pready.
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; APB bus idle, req_ready_o=1
// SETUP | APB setup phase: psel=1, penable=0 (one cycle)
// ACCESS| APB access phase: psel=1, penable=1 until pready or timeout
// RESP  | response presented (rsp_valid_o=1) until rsp_ready_i
//
// Parameters:
//   ADDR_WIDTH     request / APB address width
//   DATA_WIDTH     data width (multiple of 8)
//   TIMEOUT_CYCLES ACCESS-phase cycle limit, 0 disables the watchdog
//
// Ports:
//   pclk_i, preset_ni          clock, async active-low reset
//   req_valid_i / req_ready_o  request handshake
//   req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i  payload
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o, rsp_timeout_o                        response
//   paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o  APB out
//   pready_i, prdata_i, pslverr_i                                   APB in
// -----------------------------------------------------------------------------
module apb_req_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam bit TO_EN      = (TIMEOUT_CYCLES > 0);
  // Counter is sized to hold T; it shrinks to a single unused bit when the
  // watchdog is disabled.
  localparam int TW         = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value seen during the T-th ACCESS cycle (counts 0..T-1).
  localparam logic [TW-1:0] TLIM = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_done;
  logic   w_timeout;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_prot;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;

  logic [TW-1:0]         r_tcnt;

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_timeout;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // pready wins over the watchdog when both land in the same cycle.
        if (pready_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (TO_EN && (r_tcnt == TLIM)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Decoded straight from the state register so reset clears them without
  // waiting for a clock edge.
  assign req_ready_o = (r_state == S_IDLE);
  assign psel_o      = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable_o   = (r_state == S_ACCESS);
  assign rsp_valid_o = (r_state == S_RESP);

  // ---------------------------------------------------------------------------
  // Request payload: loaded only on acceptance, so it holds through the
  // transfer and keeps its last value in IDLE/RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_addr  <= '0;
      r_prot  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_accept) begin
      r_addr  <= req_addr_i;
      r_prot  <= req_prot_i;
      r_write <= req_write_i;
      r_wdata <= req_wdata_i;
      r_strb  <= req_strb_i;
    end
  end

  assign paddr_o  = r_addr;
  assign pprot_o  = r_prot;
  assign pwrite_o = r_write;
  assign pwdata_o = r_wdata;
  assign pstrb_o  = r_strb;

  // ---------------------------------------------------------------------------
  // ACCESS watchdog: cleared in SETUP so it starts at 0 on ACCESS entry;
  // saturates instead of wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_tcnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_tcnt <= '0;
    end else if ((r_state == S_ACCESS) && !pready_i && (r_tcnt != '1)) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_done) begin
      r_rdata   <= r_write ? '0 : prdata_i;
      r_err     <= pslverr_i;
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_rdata   <= '0;
      r_err     <= 1'b1;
      r_timeout <= 1'b1;
    end
  end

  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_err;
  assign rsp_timeout_o = r_timeout;

endmodule

// File: tb/tb_apb_req_master.sv
// -----------------------------------------------------------------------------
// tb_apb_req_master
//
// Directed bench for apb_req_master (TIMEOUT_CYCLES=4). Inputs are driven and
// outputs sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_apb_req_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk_i;
  logic          preset_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [DW-1:0] req_wdata_i;
  logic [3:0]    req_strb_i;
  logic [2:0]    req_prot_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] paddr_o;
  logic [2:0]    pprot_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic [3:0]    pstrb_o;
  logic          pready_i;
  logic [DW-1:0] prdata_i;
  logic          pslverr_i;

  int checks = 0;
  int errors = 0;

  apb_req_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .pclk_i        (pclk_i),
    .preset_ni     (preset_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_write_i   (req_write_i),
    .req_wdata_i   (req_wdata_i),
    .req_strb_i    (req_strb_i),
    .req_prot_i    (req_prot_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .paddr_o       (paddr_o),
    .pprot_o       (pprot_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .pwdata_o      (pwdata_o),
    .pstrb_o       (pstrb_o),
    .pready_i      (pready_i),
    .prdata_i      (prdata_i),
    .pslverr_i     (pslverr_i)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  initial begin
    preset_ni   = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_strb_i  = '0;
    req_prot_i  = '0;
    rsp_ready_i = 1'b1;
    pready_i    = 1'b0;
    prdata_i    = '0;
    pslverr_i   = 1'b0;

    // ---- reset state ----
    #1;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_psel",      psel_o, 0);
    chk("rst_penable",   penable_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_paddr",     paddr_o, 0);
    chk("rst_rdata",     rsp_rdata_o, 0);
    tick();
    tick();
    preset_ni = 1'b1;
    tick();

    // ---- read, zero wait states ----
    req_valid_i = 1'b1;
    req_addr_i  = 32'h10;
    req_write_i = 1'b0;
    req_prot_i  = 3'b010;
    pready_i    = 1'b1;
    prdata_i    = 32'hCAFE_0001;
    tick();                                   // SETUP
    req_valid_i = 1'b0;
    chk("rd_setup_psel",    psel_o, 1);
    chk("rd_setup_penable", penable_o, 0);
    chk("rd_setup_paddr",   paddr_o, 32'h10);
    chk("rd_setup_pprot",   pprot_o, 3'b010);
    chk("rd_setup_pwrite",  pwrite_o, 0);
    chk("rd_setup_rdy",     req_ready_o, 0);
    tick();                                   // ACCESS
    chk("rd_acc_psel",    psel_o, 1);
    chk("rd_acc_penable", penable_o, 1);
    chk("rd_acc_rspv",    rsp_valid_o, 0);
    tick();                                   // RESP
    chk("rd_resp_psel",  psel_o, 0);
    chk("rd_resp_pen",   penable_o, 0);
    chk("rd_resp_valid", rsp_valid_o, 1);
    chk("rd_resp_rdata", rsp_rdata_o, 32'hCAFE_0001);
    chk("rd_resp_err",   rsp_err_o, 0);
    chk("rd_resp_to",    rsp_timeout_o, 0);
    pready_i = 1'b0;
    tick();                                   // IDLE
    chk("rd_idle_valid", rsp_valid_o, 0);
    chk("rd_idle_rdy",   req_ready_o, 1);
    chk("rd_idle_paddr", paddr_o, 32'h10);

    // ---- write, 3 wait states, slave error, limit coincides with pready ----
    req_valid_i = 1'b1;
    req_addr_i  = 32'h40;
    req_write_i = 1'b1;
    req_wdata_i = 32'h1234_5678;
    req_strb_i  = 4'hF;
    req_prot_i  = 3'b000;
    prdata_i    = 32'hDEAD_BEEF;
    tick();                                   // SETUP
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFF;                    // must be ignored
    req_wdata_i = 32'h0;
    req_strb_i  = 4'h0;
    chk("wr_setup_pwrite", pwrite_o, 1);
    chk("wr_setup_pwdata", pwdata_o, 32'h1234_5678);
    chk("wr_setup_pstrb",  pstrb_o, 4'hF);
    chk("wr_setup_paddr",  paddr_o, 32'h40);
    tick();                                   // ACCESS 1
    for (int i = 0; i < 4; i++) begin
      chk("wr_acc_penable", penable_o, 1);
      chk("wr_acc_rspv",    rsp_valid_o, 0);
      chk("wr_acc_paddr",   paddr_o, 32'h40);
      chk("wr_acc_pwdata",  pwdata_o, 32'h1234_5678);
      if (i == 3) begin
        pready_i  = 1'b1;
        pslverr_i = 1'b1;
      end
      tick();
    end
    chk("wr_resp_valid", rsp_valid_o, 1);
    chk("wr_resp_err",   rsp_err_o, 1);
    chk("wr_resp_rdata", rsp_rdata_o, 0);
    chk("wr_resp_to",    rsp_timeout_o, 0);
    chk("wr_resp_psel",  psel_o, 0);
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    tick();                                   // IDLE

    // ---- timeout, then response back-pressure ----
    req_valid_i = 1'b1;
    req_addr_i  = 32'h80;
    req_write_i = 1'b0;
    prdata_i    = 32'h7777_7777;
    tick();                                   // SETUP
    req_valid_i = 1'b0;
    tick();                                   // ACCESS 1
    for (int i = 0; i < 4; i++) begin
      chk("to_acc_psel",    psel_o, 1);
      chk("to_acc_penable", penable_o, 1);
      if (i == 3) rsp_ready_i = 1'b0;
      tick();
    end
    // new request presented while the response is stalled
    req_valid_i = 1'b1;
    req_addr_i  = 32'h90;
    for (int i = 0; i < 5; i++) begin
      chk("to_hold_psel",  psel_o, 0);
      chk("to_hold_valid", rsp_valid_o, 1);
      chk("to_hold_err",   rsp_err_o, 1);
      chk("to_hold_to",    rsp_timeout_o, 1);
      chk("to_hold_rdata", rsp_rdata_o, 0);
      chk("to_hold_rdy",   req_ready_o, 0);
      tick();
    end
    rsp_ready_i = 1'b1;
    chk("to_hold_last_valid", rsp_valid_o, 1);
    tick();                                   // IDLE
    chk("bp_idle_rdy",  req_ready_o, 1);
    chk("bp_idle_psel", psel_o, 0);
    pready_i = 1'b1;
    prdata_i = 32'h0000_0090;
    tick();                                   // SETUP for 0x90
    req_valid_i = 1'b0;
    chk("bp_setup_paddr", paddr_o, 32'h90);
    chk("bp_setup_psel",  psel_o, 1);
    tick();                                   // ACCESS
    tick();                                   // RESP
    chk("bp_resp_valid", rsp_valid_o, 1);
    chk("bp_resp_rdata", rsp_rdata_o, 32'h0000_0090);
    chk("bp_resp_to",    rsp_timeout_o, 0);
    chk("bp_resp_err",   rsp_err_o, 0);
    pready_i = 1'b0;
    tick();                                   // IDLE

    // ---- reset pulse during ACCESS ----
    req_valid_i = 1'b1;
    req_addr_i  = 32'hA0;
    tick();                                   // SETUP
    req_valid_i = 1'b0;
    tick();                                   // ACCESS
    chk("rst_acc_psel", psel_o, 1);
    #2;
    preset_ni = 1'b0;
    #1;
    chk("arst_psel",    psel_o, 0);
    chk("arst_penable", penable_o, 0);
    chk("arst_rdy",     req_ready_o, 1);
    chk("arst_rspv",    rsp_valid_o, 0);
    chk("arst_paddr",   paddr_o, 0);
    #3;
    preset_ni = 1'b1;
    tick();
    chk("post_rst_rspv", rsp_valid_o, 0);
    chk("post_rst_rdy",  req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = 32'hB0;
    pready_i    = 1'b1;
    prdata_i    = 32'h0000_0055;
    tick();                                   // SETUP
    req_valid_i = 1'b0;
    chk("post_rst_paddr", paddr_o, 32'hB0);
    tick();                                   // ACCESS
    tick();                                   // RESP
    chk("post_rst_valid", rsp_valid_o, 1);
    chk("post_rst_rdata", rsp_rdata_o, 32'h0000_0055);
    pready_i = 1'b0;
    tick();                                   // IDLE

    // ---- 8 back-to-back reads, req_valid held high ----
    req_valid_i = 1'b1;
    pready_i    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_rdy", req_ready_o, 1);
      req_addr_i = 32'h100 + 32'(4 * k);
      tick();                                 // SETUP
      chk("b2b_paddr", paddr_o, 32'h100 + 32'(4 * k));
      chk("b2b_psel",  psel_o, 1);
      tick();                                 // ACCESS
      prdata_i = 32'hA000 + 32'(k);
      tick();                                 // RESP
      chk("b2b_valid", rsp_valid_o, 1);
      chk("b2b_rdata", rsp_rdata_o, 32'hA000 + 32'(k));
      tick();                                 // IDLE
    end
    req_valid_i = 1'b0;
    pready_i    = 1'b0;
    tick();
    chk("end_idle_rdy",  req_ready_o, 1);
    chk("end_idle_psel", psel_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
